hc_stream_copy: RTL and testbench

// - Core-side stream engine directly upstream of the CCI-P requestor: turns one start into a buffer-to-buffer copy.
// - Issues chunked READ_STREAM requests on source buffer SRC_ID and collects the returned lines in a local data FIFO.
// - Reissues each line as a WRITE_STREAM request with data on destination buffer DST_ID.
// - Raises finish once every line has been handed to the requestor, which then writes the DSM completion flag.

---
 rtl/hc_stream_copy.sv | 137 +++++++++++++
 tb/tb_hc_stream_copy.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_stream_copy.sv
// Buffer-to-buffer copy engine: chunked READ_STREAM requests on SRC_ID, returned lines
// buffered in a local FIFO, then reissued one per cycle as WRITE_STREAM requests on DST_ID.
module hc_stream_copy #(
  parameter int unsigned CHUNK      = 16,
  parameter int unsigned DATA_DEPTH = 64,
  parameter int unsigned LEN_W      = 32,
  parameter int unsigned SRC_ID     = 0,
  parameter int unsigned DST_ID     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] src_lines,
  output logic [1:0]       rd_req_cmd,
  output logic [7:0]       rd_req_id,
  output logic [9:0]       rd_req_offset,
  input  logic             rd_req_full,
  input  logic             rx_valid,
  input  logic [511:0]     rx_data,
  output logic [1:0]       wr_req_cmd,
  output logic [7:0]       wr_req_id,
  output logic [511:0]     wr_req_data,
  input  logic             wr_req_full,
  output logic             finish,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0]  CMD_NONE = 2'd0;
  localparam logic [1:0]  CMD_RD   = 2'd1;
  localparam logic [1:0]  CMD_WR   = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic             start_q, start_rise, start_fall, active;
  logic [LEN_W-1:0] total, rd_issued, wr_written, rd_left;
  logic [CW-1:0]    outstanding, fifo_count;
  logic [CW:0]      in_use, credit;
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [9:0]       chunk;
  logic             rd_issue, push, pop, fifo_empty, fifo_full;
  logic             overflow_err;
  logic [511:0]     mem [DATA_DEPTH];

  always_comb begin
    start_rise = start & ~start_q;
    start_fall = ~start & start_q;
    busy       = (state == RUN);
    active     = (state == RUN) && !start_fall;
    fifo_count = wr_ptr - rd_ptr;
    fifo_empty = (fifo_count == '0);
    fifo_full  = (fifo_count == CW'(DATA_DEPTH));
    rd_left    = total - rd_issued;
    chunk      = (rd_left < LEN_W'(CHUNK)) ? rd_left[9:0] : 10'(CHUNK);
    in_use     = {1'b0, outstanding} + {1'b0, fifo_count};
    credit     = (CW+1)'(DATA_DEPTH) - in_use;
    // the rd_req_cmd term spaces issues two cycles apart to cover the lag on rd_req_full
    rd_issue   = active && (rd_left != '0) && !rd_req_full && (rd_req_cmd == CMD_NONE) &&
                 (LEN_W'(credit) >= LEN_W'(chunk));
    push       = active && rx_valid;
    pop        = active && !fifo_empty && !wr_req_full;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_rise) state_nxt = (src_lines == '0) ? DONE : RUN;
      // DONE is entered on the edge that launches the final write pulse
      RUN:  if (start_fall) state_nxt = IDLE;
            else if ((wr_written + LEN_W'(pop)) == total) state_nxt = DONE;
      DONE: if (start_fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      start_q       <= 1'b0;
      total         <= '0;
      rd_issued     <= '0;
      wr_written    <= '0;
      outstanding   <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      rd_req_cmd    <= CMD_NONE;
      rd_req_id     <= '0;
      rd_req_offset <= '0;
      wr_req_cmd    <= CMD_NONE;
      wr_req_id     <= '0;
      wr_req_data   <= '0;
      finish        <= 1'b0;
      overflow_err  <= 1'b0;
    end else begin
      state         <= state_nxt;
      start_q       <= start;
      finish        <= (state == DONE) && !start_fall;
      rd_req_cmd    <= rd_issue ? CMD_RD : CMD_NONE;
      rd_req_id     <= rd_issue ? 8'(SRC_ID) : '0;
      rd_req_offset <= rd_issue ? chunk : '0;
      wr_req_cmd    <= pop ? CMD_WR : CMD_NONE;
      wr_req_id     <= pop ? 8'(DST_ID) : '0;
      if (pop) wr_req_data <= mem[rd_ptr[AW-1:0]];
      overflow_err  <= overflow_err | (push && fifo_full && !pop);

      if (state == IDLE && start_rise) begin
        total       <= src_lines;
        rd_issued   <= '0;
        wr_written  <= '0;
        outstanding <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else if (state == RUN && start_fall) begin
        outstanding <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
      end else begin
        if (rd_issue) rd_issued <= rd_issued + LEN_W'(chunk);
        outstanding <= outstanding + (rd_issue ? CW'(chunk) : '0) - (push ? CW'(1) : '0);
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop) begin
          rd_ptr     <= rd_ptr + (AW+1)'(1);
          wr_written <= wr_written + LEN_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !overflow_err);

endmodule

// File: tb/tb_hc_stream_copy.sv
// Directed bench for hc_stream_copy: a requestor model answers reads and feeds a scoreboard
// of expected write lines; a monitor pops and compares every write pulse.
module tb_hc_stream_copy;

  logic         clk = 1'b0;
  logic         reset, start, rd_full, wr_full, rx_valid, sel;
  logic [31:0]  src_lines;
  logic [511:0] rx_data;

  logic [1:0]   a_rd_cmd, b_rd_cmd, a_wr_cmd, b_wr_cmd;
  logic [7:0]   a_rd_id, b_rd_id, a_wr_id, b_wr_id;
  logic [9:0]   a_rd_off, b_rd_off;
  logic [511:0] a_wr_data, b_wr_data;
  logic         a_finish, b_finish, a_busy, b_busy, a_start, b_start;

  logic [1:0]   rd_cmd, wr_cmd;
  logic [7:0]   rd_id, wr_id;
  logic [9:0]   rd_off;
  logic [511:0] wr_data;
  logic         finish, busy;

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign rd_cmd  = sel ? b_rd_cmd  : a_rd_cmd;
  assign rd_id   = sel ? b_rd_id   : a_rd_id;
  assign rd_off  = sel ? b_rd_off  : a_rd_off;
  assign wr_cmd  = sel ? b_wr_cmd  : a_wr_cmd;
  assign wr_id   = sel ? b_wr_id   : a_wr_id;
  assign wr_data = sel ? b_wr_data : a_wr_data;
  assign finish  = sel ? b_finish  : a_finish;
  assign busy    = sel ? b_busy    : a_busy;

  hc_stream_copy #(.CHUNK(16), .DATA_DEPTH(64), .LEN_W(32), .SRC_ID(0), .DST_ID(1)) u_dut (
    .clk(clk), .reset(reset), .start(a_start), .src_lines(src_lines),
    .rd_req_cmd(a_rd_cmd), .rd_req_id(a_rd_id), .rd_req_offset(a_rd_off), .rd_req_full(rd_full),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_req_cmd(a_wr_cmd), .wr_req_id(a_wr_id), .wr_req_data(a_wr_data), .wr_req_full(wr_full),
    .finish(a_finish), .busy(a_busy));

  hc_stream_copy #(.CHUNK(16), .DATA_DEPTH(16), .LEN_W(32), .SRC_ID(0), .DST_ID(1)) u_dut16 (
    .clk(clk), .reset(reset), .start(b_start), .src_lines(src_lines),
    .rd_req_cmd(b_rd_cmd), .rd_req_id(b_rd_id), .rd_req_offset(b_rd_off), .rd_req_full(rd_full),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .wr_req_cmd(b_wr_cmd), .wr_req_id(b_wr_id), .wr_req_data(b_wr_data), .wr_req_full(wr_full),
    .finish(b_finish), .busy(b_busy));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, wr_count = 0, rd_pulses = 0, fin_hi = 0;
  int last_wr_cyc = 0, fin_cyc = 0;
  int junk_req = 0, junk_sent = 0;
  logic flush_req = 1'b0;
  logic [511:0] exp_q[$];
  int rd_offs[$];

  function automatic logic [511:0] mk(input logic [31:0] s);
    return {8{~s, s}};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check512(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // requestor read side: capture read pulses, return that many lines, record them as expected writes
  initial begin : req_model
    int pending;
    logic [31:0] seq;
    pending  = 0;
    seq      = 32'h0001_0000;
    rx_valid = 1'b0;
    rx_data  = '0;
    forever begin
      @(negedge clk);
      if (flush_req) pending = 0;
      if (rd_cmd == 2'd1) begin
        rd_pulses++;
        rd_offs.push_back(int'(rd_off));
        pending += int'(rd_off);
        check("rd_id", 64'(rd_id), 64'd0);
      end
      rx_valid = 1'b0;
      if (junk_sent < junk_req) begin
        rx_valid = 1'b1;
        rx_data  = {16{32'hDEAD_0000 + 32'(junk_sent)}};
        junk_sent++;
      end else if (pending > 0 && !flush_req) begin
        rx_valid = 1'b1;
        rx_data  = mk(seq);
        exp_q.push_back(mk(seq));
        seq++;
        pending--;
      end
    end
  end

  initial begin : monitor
    logic fin_prev;
    fin_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (wr_cmd == 2'd3) begin
        wr_count++;
        last_wr_cyc = cyc;
        check("wr_id", 64'(wr_id), 64'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL wr_extra: write pulse with data %h but no line expected", wr_data);
        end else begin
          check512("wr_data", wr_data, exp_q.pop_front());
        end
      end
      if (finish) fin_hi++;
      if (finish && !fin_prev) fin_cyc = cyc;
      fin_prev = finish;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_copy(input logic [31:0] n);
    tick();
    src_lines = n;
    start = 1'b1;
  endtask

  task automatic stop_copy();
    tick();
    start = 1'b0;
    repeat (2) tick();
    check("finish_after_stop", 64'(finish), 64'd0);
  endtask

  task automatic wait_done(input int maxc, input string nm);
    for (int i = 0; i < maxc && !finish; i++) tick();
    check(nm, 64'(finish), 64'd1);
  endtask

  task automatic wait_writes(input int base, input int n, input int maxc);
    for (int i = 0; i < maxc && (wr_count - base) < n; i++) tick();
    check("wait_writes", 64'(wr_count - base), 64'(n));
  endtask

  task automatic check_offs(input int base, input int o0, input int o1, input int o2, input string nm);
    int exp_n;
    int exp_o[3];
    exp_o[0] = o0; exp_o[1] = o1; exp_o[2] = o2;
    exp_n = (o2 == 0) ? 2 : 3;
    check({nm, "_rd_count"}, 64'(rd_offs.size() - base), 64'(exp_n));
    for (int i = 0; i < exp_n && base + i < rd_offs.size(); i++)
      check({nm, "_rd_off"}, 64'(rd_offs[base + i]), 64'(exp_o[i]));
  endtask

  initial begin : stim
    int wb, rb, ob, fb, sum;
    reset = 1'b1; start = 1'b0; rd_full = 1'b0; wr_full = 1'b0; sel = 1'b0; src_lines = '0;
    repeat (3) tick();
    check("rst_rd_cmd", 64'(rd_cmd), 64'd0);
    check("rst_wr_cmd", 64'(wr_cmd), 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    reset = 1'b0;
    repeat (2) tick();

    // 40 lines, no backpressure
    wb = wr_count; ob = rd_offs.size();
    start_copy(40);
    wait_done(400, "t40_finish");
    check("t40_writes", 64'(wr_count - wb), 64'd40);
    check_offs(ob, 16, 16, 8, "t40");
    check("t40_finish_lat", 64'(fin_cyc - last_wr_cyc), 64'd1);
    check("t40_sb_empty", 64'(exp_q.size()), 64'd0);
    check("t40_busy_done", 64'(busy), 64'd0);
    stop_copy();

    // zero-length copy
    rb = rd_pulses; wb = wr_count;
    start_copy(0);
    tick();
    check("z_finish_c1", 64'(finish), 64'd0);
    tick();
    check("z_finish_c2", 64'(finish), 64'd1);
    check("z_rd_pulses", 64'(rd_pulses - rb), 64'd0);
    check("z_writes", 64'(wr_count - wb), 64'd0);
    stop_copy();

    // read queue full for 50 cycles
    rb = rd_pulses; wb = wr_count; ob = rd_offs.size();
    rd_full = 1'b1;
    start_copy(20);
    repeat (50) tick();
    check("rf_no_issue", 64'(rd_pulses - rb), 64'd0);
    rd_full = 1'b0;
    tick();
    check("rf_resume", 64'(rd_cmd), 64'd1);
    wait_done(300, "rf_finish");
    check("rf_writes", 64'(wr_count - wb), 64'd20);
    check_offs(ob, 16, 4, 0, "rf");
    stop_copy();

    // 200 lines streaming continuously
    rb = rd_pulses; wb = wr_count; ob = rd_offs.size();
    start_copy(200);
    wait_done(1500, "s200_finish");
    check("s200_writes", 64'(wr_count - wb), 64'd200);
    check("s200_rd_pulses", 64'(rd_pulses - rb), 64'd13);
    sum = 0;
    for (int i = ob; i < rd_offs.size(); i++) sum += rd_offs[i];
    check("s200_rd_lines", 64'(sum), 64'd200);
    check("s200_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_copy();

    // DATA_DEPTH=16 instance with writes blocked
    sel = 1'b1;
    tick();
    rb = rd_pulses; wb = wr_count; ob = rd_offs.size();
    wr_full = 1'b1;
    start_copy(40);
    repeat (60) tick();
    check("d16_one_read", 64'(rd_pulses - rb), 64'd1);
    check("d16_no_writes", 64'(wr_count - wb), 64'd0);
    check("d16_busy", 64'(busy), 64'd1);
    wr_full = 1'b0;
    wait_done(400, "d16_finish");
    check("d16_writes", 64'(wr_count - wb), 64'd40);
    check_offs(ob, 16, 16, 8, "d16");
    stop_copy();
    sel = 1'b0;
    tick();

    // abort after 10 lines, late beats, then a full restart
    wb = wr_count; fb = fin_hi;
    start_copy(40);
    wait_writes(wb, 10, 300);
    start = 1'b0;
    tick();
    check("ab_busy", 64'(busy), 64'd0);
    flush_req = 1'b1;
    repeat (3) tick();
    flush_req = 1'b0;
    exp_q.delete();
    junk_req = junk_sent + 3;
    repeat (8) tick();
    check("ab_writes", 64'(wr_count - wb), 64'd10);
    check("ab_no_finish", 64'(fin_hi - fb), 64'd0);
    check("ab_idle_busy", 64'(busy), 64'd0);
    wb = wr_count; ob = rd_offs.size();
    start_copy(40);
    wait_done(400, "re_finish");
    check("re_writes", 64'(wr_count - wb), 64'd40);
    check_offs(ob, 16, 16, 8, "re");
    check("re_sb_empty", 64'(exp_q.size()), 64'd0);
    stop_copy();

    // reset in the middle of a copy
    wb = wr_count;
    start_copy(40);
    wait_writes(wb, 5, 300);
    reset = 1'b1; start = 1'b0; flush_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mr_rd_cmd", 64'(rd_cmd), 64'd0);
      check("mr_wr_cmd", 64'(wr_cmd), 64'd0);
      check("mr_busy",   64'(busy),   64'd0);
    end
    reset = 1'b0; flush_req = 1'b0;
    exp_q.delete();
    repeat (4) tick();
    check("mr_finish", 64'(finish), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
